// File: rtl/llsc_commit_unit_pkg.sv
// Shared types and defaults for the LL/SC commit unit.
package llsc_commit_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } sc_state_e;

  function automatic logic word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/llsc_commit_unit_if.sv
// Store request channel from the commit unit to the data bus.
interface llsc_commit_unit_if
  import llsc_commit_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/llsc_commit_unit_link_reg.sv
// Link bit and linked word address, with LL set, explicit clear and snoop kill.
module llsc_link_reg
  import llsc_commit_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-3:0] set_word,
  input  logic              clr,
  input  logic              snoop_we,
  input  logic [ADDR_W-3:0] snoop_word,
  output logic              llbit,
  output logic [ADDR_W-3:0] link_word,
  output logic              snoop_hit
);

  assign snoop_hit = llbit & snoop_we & (snoop_word == link_word);

  // Clear beats a new link; a new link beats a same-cycle snoop kill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit     <= 1'b0;
      link_word <= '0;
    end else if (clr) begin
      llbit     <= 1'b0;
    end else if (set) begin
      llbit     <= 1'b1;
      link_word <= set_word;
    end else if (snoop_hit) begin
      llbit     <= 1'b0;
    end
  end

endmodule

// File: rtl/llsc_commit_unit.sv
// LL/SC commit unit: link tracking plus the SC store/complete sequencer.
module llsc_commit_unit
  import llsc_commit_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ll_valid,
  input  logic [ADDR_W-1:0]        ll_addr,
  input  logic                     sc_valid,
  input  logic [ADDR_W-1:0]        sc_addr,
  input  logic [DATA_W-1:0]        sc_data,
  input  logic                     flush,
  input  logic                     snoop_we,
  input  logic [ADDR_W-1:0]        snoop_addr,
  llsc_commit_unit_if.master       bus,
  output logic                     stall_o,
  output logic                     sc_done,
  output logic                     sc_result,
  output logic                     llbit_o
);

  sc_state_e         state_q, state_d;
  logic              flush_seen_q, flush_seen_d;
  logic              result_q, result_d;
  logic              load_bus;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              llbit;
  logic [ADDR_W-3:0] link_word;
  logic              snoop_hit;
  logic              sc_accept;
  logic              sc_ok;
  logic              unused_lsbs;

  assign unused_lsbs = ^{ll_addr[1:0], snoop_addr[1:0]};

  assign sc_accept = (state_q == ST_IDLE) & sc_valid & ~flush;
  assign sc_ok     = llbit & (sc_addr[ADDR_W-1:2] == link_word)
                   & word_aligned(sc_addr[1:0]) & ~snoop_hit;

  llsc_link_reg #(
    .ADDR_W (ADDR_W)
  ) u_link_reg (
    .clk        (clk),
    .rst        (rst),
    .set        (ll_valid & ~flush & ~sc_accept),
    .set_word   (ll_addr[ADDR_W-1:2]),
    .clr        (flush | (state_q == ST_DONE)),
    .snoop_we   (snoop_we),
    .snoop_word (snoop_addr[ADDR_W-1:2]),
    .llbit      (llbit),
    .link_word  (link_word),
    .snoop_hit  (snoop_hit)
  );

  // Next state; a flush seen while the store is in flight diverts completion to DRAIN.
  always_comb begin
    state_d      = state_q;
    flush_seen_d = flush_seen_q;
    result_d     = result_q;
    load_bus     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush_seen_d = 1'b0;
        if (sc_accept) begin
          if (sc_ok) begin
            load_bus = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            result_d = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.mem_ack) begin
          if (flush | flush_seen_q) begin
            state_d = ST_DRAIN;
          end else begin
            result_d = 1'b1;
            state_d  = ST_DONE;
          end
        end else if (flush) begin
          flush_seen_d = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, result and captured store beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      flush_seen_q <= 1'b0;
      result_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_seen_q <= flush_seen_d;
      result_q     <= result_d;
      if (load_bus) begin
        mem_addr_q  <= {sc_addr[ADDR_W-1:2], 2'b00};
        mem_wdata_q <= sc_data;
      end
    end
  end

  assign bus.mem_req   = (state_q == ST_WRITE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign sc_done   = (state_q == ST_DONE);
  assign sc_result = result_q;
  assign llbit_o   = llbit;

  // Gated by rst so the pipeline is released immediately while reset is held.
  assign stall_o = rst & (((state_q == ST_IDLE) & sc_valid & ~flush)
                          | (state_q == ST_WRITE)
                          | (state_q == ST_DRAIN));

endmodule

// File: tb/tb_llsc_commit_unit.sv
module tb_llsc_commit_unit;
  import llsc_commit_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ll_valid = 1'b0, sc_valid = 1'b0, flush = 1'b0, snoop_we = 1'b0;
  logic [31:0] ll_addr = '0, sc_addr = '0, sc_data = '0, snoop_addr = '0;
  logic        stall_o, sc_done, sc_result, llbit_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  llsc_commit_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  llsc_commit_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ll_valid   (ll_valid),
    .ll_addr    (ll_addr),
    .sc_valid   (sc_valid),
    .sc_addr    (sc_addr),
    .sc_data    (sc_data),
    .flush      (flush),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .bus        (bus),
    .stall_o    (stall_o),
    .sc_done    (sc_done),
    .sc_result  (sc_result),
    .llbit_o    (llbit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ll_a;
    bit          pre_snoop;
    bit          same_snoop;
    logic [31:0] snp_a;
    logic [31:0] sc_a;
    logic [31:0] sc_d;
    int unsigned wait_c;
    bit          exp_res;
    int unsigned exp_req;
    int unsigned exp_lat;
  } vec_t;

  typedef struct {
    bit          done;
    bit          result;
    int unsigned req_cycles;
    int unsigned latency;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          stall0;
    bit          stall_done;
    bit          stable;
  } obs_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_ll(input logic [31:0] a, input bit with_flush);
    @(negedge clk);
    ll_valid = 1'b1; ll_addr = a; flush = with_flush;
    @(negedge clk);
    ll_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_snoop(input logic [31:0] a);
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = a;
    @(negedge clk);
    snoop_we = 1'b0;
  endtask

  // Presents one SC, acks the store on its (wait_c+1)-th request cycle, bounded.
  task automatic run_sc(input logic [31:0] a, input logic [31:0] d, input int unsigned wait_c,
                        input bit snp, input logic [31:0] snp_a, output obs_t o);
    o.done = 0; o.result = 0; o.req_cycles = 0; o.latency = 0;
    o.addr = '0; o.wdata = '0; o.stall0 = 0; o.stall_done = 1; o.stable = 1;
    @(negedge clk);
    sc_valid = 1'b1; sc_addr = a; sc_data = d; snoop_we = snp; snoop_addr = snp_a;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (cyc == 0) o.stall0 = stall_o;
      if (bus.mem_req) begin
        if (o.req_cycles > 0 && (bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata)) o.stable = 0;
        o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
        o.req_cycles++;
        if (o.req_cycles == wait_c + 1) bus.mem_ack = 1'b1;
      end
      if (sc_done) begin
        o.done = 1; o.result = sc_result; o.latency = cyc; o.stall_done = stall_o;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0; snoop_we = 1'b0;
      if (o.done) break;
    end
    sc_valid = 1'b0;
  endtask

  vec_t        vecs[7];
  obs_t        o;
  int unsigned op, w;
  logic [31:0] a, d;
  bit          exp_ok, m_link, seen_done;
  logic [29:0] m_word;

  initial begin
    bus.mem_ack = 1'b0;

    //             ll_a          pre same snp_a         sc_a          sc_d          wait res req lat
    vecs[0] = '{32'h0000_1000, 0, 0, 32'h0,        32'h0000_1000, 32'hDEAD_BEEF, 2, 1, 3, 4};
    vecs[1] = '{32'h0000_1000, 1, 0, 32'h0000_1002, 32'h0000_1000, 32'h1111_1111, 0, 0, 0, 1};
    vecs[2] = '{32'h0000_1000, 0, 0, 32'h0,        32'h0000_1004, 32'h2222_2222, 0, 0, 0, 1};
    vecs[3] = '{32'h0000_1000, 0, 0, 32'h0,        32'h0000_1002, 32'h4444_4444, 0, 0, 0, 1};
    vecs[4] = '{32'h0000_2000, 1, 0, 32'h0000_2004, 32'h0000_2000, 32'h1234_5678, 0, 1, 1, 2};
    vecs[5] = '{32'h0000_3000, 0, 1, 32'h0000_3001, 32'h0000_3000, 32'h3333_3333, 0, 0, 0, 1};
    vecs[6] = '{32'hFFFF_FFFC, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 1, 2, 3};

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst sc_done", sc_done, 0);
    chk("rst sc_result", sc_result, 0);
    chk("rst llbit", llbit_o, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst stall", stall_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post-rst llbit", llbit_o, 0);
    chk("post-rst mem_req", bus.mem_req, 0);

    // table-driven SC scenarios
    foreach (vecs[i]) begin
      do_ll(vecs[i].ll_a, 1'b0); #1;
      chk($sformatf("v%0d ll llbit", i), llbit_o, 1);
      if (vecs[i].pre_snoop) begin
        do_snoop(vecs[i].snp_a); #1;
      end
      run_sc(vecs[i].sc_a, vecs[i].sc_d, vecs[i].wait_c, vecs[i].same_snoop, vecs[i].snp_a, o);
      chk($sformatf("v%0d done", i), o.done, 1);
      chk($sformatf("v%0d result", i), o.result, vecs[i].exp_res);
      chk($sformatf("v%0d req cycles", i), o.req_cycles, vecs[i].exp_req);
      chk($sformatf("v%0d latency", i), o.latency, vecs[i].exp_lat);
      chk($sformatf("v%0d stall accept", i), o.stall0, 1);
      chk($sformatf("v%0d stall done", i), o.stall_done, 0);
      if (vecs[i].exp_req != 0) begin
        chk($sformatf("v%0d mem_addr", i), o.addr, vecs[i].sc_a & 32'hFFFF_FFFC);
        chk($sformatf("v%0d mem_wdata", i), o.wdata, vecs[i].sc_d);
        chk($sformatf("v%0d req stable", i), o.stable, 1);
      end
      #1;
      chk($sformatf("v%0d done one pulse", i), sc_done, 0);
      chk($sformatf("v%0d llbit after", i), llbit_o, 0);
    end

    // flush while the store is in flight: bus completes, no sc_done, DRAIN then release
    do_ll(32'h0000_5000, 1'b0);
    @(negedge clk);
    sc_valid = 1'b1; sc_addr = 32'h0000_5000; sc_data = 32'hCAFE_F00D;
    @(negedge clk); #1;
    chk("flush write req", bus.mem_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; sc_valid = 1'b0;
    seen_done = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("flush req held %0d", k), bus.mem_req, 1);
      chk($sformatf("flush stall %0d", k), stall_o, 1);
      if (sc_done) seen_done = 1;
      if (k == 3) bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    #1;
    chk("drain mem_req", bus.mem_req, 0);
    chk("drain stall", stall_o, 1);
    if (sc_done) seen_done = 1;
    @(negedge clk); #1;
    chk("after drain stall", stall_o, 0);
    if (sc_done) seen_done = 1;
    chk("flush no sc_done", seen_done, 0);
    chk("flush llbit", llbit_o, 0);

    // reset asserted mid-WRITE
    do_ll(32'h0000_6000, 1'b0);
    @(negedge clk);
    sc_valid = 1'b1; sc_addr = 32'h0000_6000; sc_data = 32'h5555_AAAA;
    @(negedge clk); #1;
    chk("pre-rst mem_req", bus.mem_req, 1);
    chk("pre-rst llbit", llbit_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst mem_req", bus.mem_req, 0);
    chk("async rst llbit", llbit_o, 0);
    chk("async rst stall", stall_o, 0);
    chk("async rst mem_addr", bus.mem_addr, 0);
    sc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst release mem_req", bus.mem_req, 0);
    chk("rst release stall", stall_o, 0);

    // LL with same-cycle flush
    do_ll(32'h0000_7000, 1'b1); #1;
    chk("ll+flush llbit", llbit_o, 0);

    // flush in IDLE with SC pending: not started
    do_ll(32'h0000_7000, 1'b0); #1;
    chk("ll llbit set", llbit_o, 1);
    @(negedge clk);
    sc_valid = 1'b1; sc_addr = 32'h0000_7000; flush = 1'b1;
    #1;
    chk("idle flush stall", stall_o, 0);
    @(negedge clk);
    sc_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle flush sc_done", sc_done, 0);
    chk("idle flush mem_req", bus.mem_req, 0);
    @(negedge clk); #1;
    chk("idle flush sc_done +1", sc_done, 0);

    // LL and SC together: SC wins, link not set
    @(negedge clk);
    sc_valid = 1'b1; sc_addr = 32'h0000_7100; ll_valid = 1'b1; ll_addr = 32'h0000_7100;
    @(negedge clk);
    ll_valid = 1'b0;
    #1;
    chk("sc prio sc_done", sc_done, 1);
    chk("sc prio result", sc_result, 0);
    chk("sc prio llbit", llbit_o, 0);
    @(negedge clk);
    sc_valid = 1'b0;
    #1;
    chk("sc prio done pulse", sc_done, 0);

    // randomized LL/snoop/SC traffic against a transaction-level link model
    m_link = 0; m_word = '0;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      a  = 32'h0000_8000 + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 4) == 0) a = a + $urandom_range(1, 3);
      case (op)
        0: begin
          do_ll(a, 1'b0);
          m_link = 1; m_word = a[31:2];
        end
        1: begin
          do_snoop(a);
          if (m_link && a[31:2] == m_word) m_link = 0;
        end
        default: begin
          w = $urandom_range(0, 3);
          d = $urandom;
          exp_ok = m_link && (a[31:2] == m_word) && (a[1:0] == 2'b00);
          run_sc(a, d, w, 1'b0, 32'h0, o);
          m_link = 0;
          chk($sformatf("r%0d done", it), o.done, 1);
          chk($sformatf("r%0d result", it), o.result, exp_ok);
          chk($sformatf("r%0d req cycles", it), o.req_cycles, exp_ok ? w + 1 : 0);
          chk($sformatf("r%0d latency", it), o.latency, exp_ok ? w + 2 : 1);
          if (exp_ok) begin
            chk($sformatf("r%0d mem_addr", it), o.addr, {a[31:2], 2'b00});
            chk($sformatf("r%0d mem_wdata", it), o.wdata, d);
          end
        end
      endcase
      #1;
      chk($sformatf("r%0d llbit", it), llbit_o, m_link);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/llsc_commit_unit.md
LLSC_COMMIT_UNIT -- requirements
Module: llsc_commit_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, load/store byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, store data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have port ll_valid  input  1  LL committing this cycle.
REQ-006 SHALL have port ll_addr  input  ADDR_W  LL effective address.
REQ-007 SHALL have port sc_valid  input  1  SC request from MEM stage; held until sc_done.
REQ-008 SHALL have port sc_addr  input  ADDR_W  SC effective address.
REQ-009 SHALL have port sc_data  input  DATA_W  SC store data.
REQ-010 SHALL have port flush  input  1  exception/ERET pipeline flush.
REQ-011 SHALL have port snoop_we  input  1  store by another master this cycle.
REQ-012 SHALL have port snoop_addr  input  ADDR_W  snooped store address.
REQ-013 SHALL have port mem_req  output  1  store request to data bus.
REQ-014 SHALL have port mem_addr  output  ADDR_W  store address, word-aligned.
REQ-015 SHALL have port mem_wdata  output  DATA_W  store data.
REQ-016 SHALL have port mem_ack  input  1  bus accepted store this cycle.
REQ-017 SHALL have port stall_o  output  1  freeze pipeline while SC pending.
REQ-018 SHALL have port sc_done  output  1  one-cycle SC completion pulse.
REQ-019 SHALL have port sc_result  output  1  value for rt: 1 success, 0 fail; valid with sc_done.
REQ-020 SHALL have port llbit_o  output  1  current link bit (CP0 visibility).

Function
REQ-021 SHALL hold link state: llbit and link word address (addr[ADDR_W-1:2]).
REQ-022 SHALL, on ll_valid with no flush, set llbit=1 and capture ll_addr word address next cycle.
REQ-023 SHALL clear llbit on flush; flush wins over ll_valid in the same cycle.
REQ-024 SHALL clear llbit when snoop_we and snoop_addr word equals link word while llbit=1.
REQ-025 SHALL implement FSM states IDLE, WRITE, DONE, DRAIN.
REQ-026 SHALL, in IDLE with sc_valid: if llbit=1, word match, sc_addr[1:0]==0, no same-cycle snoop hit and no flush -> WRITE; else -> DONE with result 0.
REQ-027 SHALL, in WRITE, assert mem_req with mem_addr=sc_addr word-aligned, mem_wdata=sc_data, stable until mem_ack; on ack -> DONE with result 1.
REQ-028 SHALL, in DONE, pulse sc_done=1 with latched sc_result for exactly one cycle, clear llbit, return to IDLE.
REQ-029 SHALL, on flush while in WRITE, keep mem_req until mem_ack (no bus abort), then enter DRAIN; DRAIN returns to IDLE next cycle without sc_done.
REQ-030 SHALL, on flush in IDLE with sc_valid, not start SC and not assert sc_done.
REQ-031 SHALL ignore snoop hits in WRITE for the in-flight SC (store already committed).
REQ-032 SHALL ignore ll_valid when sc_valid is accepted in the same cycle (SC priority).
REQ-033 SHALL drive stall_o = (IDLE & sc_valid & ~flush) | WRITE | DRAIN; stall_o=0 in DONE.
REQ-034 SHALL give minimum SC latency: fail 1 cycle to sc_done, success 2 cycles plus bus wait.
REQ-035 SHALL drive llbit_o directly from the llbit register.

Reset
REQ-036 SHALL, while rst=0, asynchronously force state=IDLE, llbit=0, link address=0, mem_req=0, sc_done=0, sc_result=0, mem_addr=0, mem_wdata=0.
REQ-037 SHALL abandon any in-flight bus request on reset (mem_req low immediately).
REQ-038 SHALL start in IDLE on the first rising clk after rst deasserts.

Structure
REQ-039 SHALL place FSM state encoding and ADDR_W/DATA_W defaults in the shared defines package.
REQ-040 SHALL instantiate one sub-module llsc_link_reg holding llbit and link address (set/clear/snoop logic).

Verification
REQ-041 SHALL test: LL 0x1000, SC 0x1000 data 0xDEADBEEF, ack after 2 cycles -> mem_req 3 cycles, sc_done with sc_result=1, llbit_o=0 after.
REQ-042 SHALL test: LL 0x1000, snoop_we at 0x1002, SC 0x1000 -> no mem_req, sc_done next cycle, sc_result=0.
REQ-043 SHALL test: LL 0x1000, SC 0x1004 -> sc_result=0, no store; llbit_o=0 afterward.
REQ-044 SHALL test: SC in WRITE, flush asserted, ack 3 cycles later -> mem_req held until ack, no sc_done, stall_o drops after DRAIN.
REQ-045 SHALL test: rst=0 mid-WRITE -> mem_req, llbit_o, stall_o all 0 without waiting for clk.
REQ-046 SHALL test: ll_valid and flush same cycle -> llbit_o stays 0.
